// File: rtl/dram_arbiter.sv
// ----------------------------------------------------------------------------
// dram_arbiter
//
// Shares one single-port data DRAM (async read, sync write, word addressed)
// between two bus masters:
//   M0 = CPU data port, M1 = program loader / DMA.
// The port is granted per burst with round-robin arbitration. A burst cap
// stops one master from starving the other. While a master owns the port,
// each cycle in which it holds its request is one beat. The beat is acked
// combinationally, and its address, data and write enable are driven onto
// the DRAM pins in the same cycle.
//
// Ports
//   cpu_clk_i      clock, all state on the rising edge
//   cpu_rst_i      asynchronous, active-high reset
//   mX_req_i       beat request; hold high for back-to-back beats
//   mX_addr_i      byte address; bits [ADDR_W+1:2] select the DRAM word
//   mX_we_i        1 = write, 0 = read
//   mX_wdata_i     write data
//   mX_ack_o       beat completed this cycle
//   mX_rdata_o     read data (DRAM spo), valid with mX_ack_o
//   dram_a_o       DRAM word address
//   dram_d_o       DRAM write data
//   dram_we_o      DRAM write enable
//   dram_spo_i     DRAM asynchronous read data
//   grant_o        00 idle, 01 M0 owns, 10 M1 owns
// ----------------------------------------------------------------------------
module dram_arbiter #(
    parameter int unsigned ADDR_W    = 16,
    parameter int unsigned DATA_W    = 32,
    parameter int unsigned MAX_BURST = 8
) (
    input  logic              cpu_clk_i,
    input  logic              cpu_rst_i,

    input  logic              m0_req_i,
    input  logic [31:0]       m0_addr_i,
    input  logic              m0_we_i,
    input  logic [DATA_W-1:0] m0_wdata_i,
    output logic              m0_ack_o,
    output logic [DATA_W-1:0] m0_rdata_o,

    input  logic              m1_req_i,
    input  logic [31:0]       m1_addr_i,
    input  logic              m1_we_i,
    input  logic [DATA_W-1:0] m1_wdata_i,
    output logic              m1_ack_o,
    output logic [DATA_W-1:0] m1_rdata_o,

    output logic [ADDR_W-1:0] dram_a_o,
    output logic [DATA_W-1:0] dram_d_o,
    output logic              dram_we_o,
    input  logic [DATA_W-1:0] dram_spo_i,

    output logic [1:0]        grant_o
);

    localparam int unsigned CNT_W = $clog2(MAX_BURST + 1);
    localparam logic [CNT_W-1:0] BURST_LAST = CNT_W'(MAX_BURST);

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_OWN0 = 2'd1;
    localparam logic [1:0] ST_OWN1 = 2'd2;

    localparam logic OWNER_M0 = 1'b0;
    localparam logic OWNER_M1 = 1'b1;

    logic [1:0]       state_q, state_d;
    logic             last_owner_q, last_owner_d;
    logic [CNT_W-1:0] beat_cnt_q, beat_cnt_d;
    logic [CNT_W-1:0] beat_cnt_inc;

    logic              own0, own1;
    logic              own_req, oth_req;
    logic [1:0]        oth_state;
    logic              beat;
    logic [31:0]       own_addr;
    logic              own_we;
    logic [DATA_W-1:0] own_wdata;

    // Only the word-select bits of each byte address reach the DRAM.
    logic unused_addr_bits;
    assign unused_addr_bits = ^{m0_addr_i[1:0], m0_addr_i[31:ADDR_W+2],
                                m1_addr_i[1:0], m1_addr_i[31:ADDR_W+2]};

    // ------------------------------------------------------------------
    // Owner-side view of the request signals
    // ------------------------------------------------------------------
    assign own0 = (state_q == ST_OWN0);
    assign own1 = (state_q == ST_OWN1);

    assign own_req   = own1 ? m1_req_i   : m0_req_i;
    assign oth_req   = own1 ? m0_req_i   : m1_req_i;
    assign oth_state = own1 ? ST_OWN0    : ST_OWN1;
    assign own_addr  = own1 ? m1_addr_i  : m0_addr_i;
    assign own_we    = own1 ? m1_we_i    : m0_we_i;
    assign own_wdata = own1 ? m1_wdata_i : m0_wdata_i;

    assign beat = (own0 | own1) & own_req;

    // ------------------------------------------------------------------
    // Combinational outputs. Everything is gated by the registered state,
    // so an asynchronous reset drops acks and dram_we_o at once and an
    // in-flight write never reaches the next edge.
    // ------------------------------------------------------------------
    always_comb begin
        dram_a_o   = '0;
        dram_d_o   = '0;
        dram_we_o  = 1'b0;
        m0_ack_o   = 1'b0;
        m1_ack_o   = 1'b0;
        m0_rdata_o = '0;
        m1_rdata_o = '0;
        if (beat) begin
            dram_a_o  = own_addr[ADDR_W+1:2];
            dram_d_o  = own_wdata;
            dram_we_o = own_we;
            if (own1) begin
                m1_ack_o   = 1'b1;
                m1_rdata_o = dram_spo_i;
            end else begin
                m0_ack_o   = 1'b1;
                m0_rdata_o = dram_spo_i;
            end
        end
    end

    assign grant_o = {own1, own0};

    // ------------------------------------------------------------------
    // Arbitration and burst tracking
    // ------------------------------------------------------------------
    assign beat_cnt_inc = beat_cnt_q + 1'b1;

    always_comb begin
        state_d      = state_q;
        last_owner_d = last_owner_q;
        beat_cnt_d   = beat_cnt_q;

        case (state_q)
            ST_IDLE: begin
                if (m0_req_i && m1_req_i) begin
                    // Tie: whoever did not own the port last goes first.
                    state_d = (last_owner_q == OWNER_M1) ? ST_OWN0 : ST_OWN1;
                end else if (m0_req_i) begin
                    state_d = ST_OWN0;
                end else if (m1_req_i) begin
                    state_d = ST_OWN1;
                end
            end

            ST_OWN0, ST_OWN1: begin
                if (!own_req) begin
                    // Owner released: hand over directly if the other waits.
                    last_owner_d = own1;
                    beat_cnt_d   = '0;
                    state_d      = oth_req ? oth_state : ST_IDLE;
                end else if (beat_cnt_inc == BURST_LAST) begin
                    // Burst cap hit on this beat. Yield only if someone waits,
                    // otherwise start a fresh burst for the same owner.
                    last_owner_d = own1;
                    beat_cnt_d   = '0;
                    if (oth_req) begin
                        state_d = oth_state;
                    end
                end else begin
                    beat_cnt_d = beat_cnt_inc;
                end
            end

            default: begin
                state_d    = ST_IDLE;
                beat_cnt_d = '0;
            end
        endcase
    end

    always_ff @(posedge cpu_clk_i or posedge cpu_rst_i) begin
        if (cpu_rst_i) begin
            state_q      <= ST_IDLE;
            last_owner_q <= OWNER_M1;
            beat_cnt_q   <= '0;
        end else begin
            state_q      <= state_d;
            last_owner_q <= last_owner_d;
            beat_cnt_q   <= beat_cnt_d;
        end
    end

endmodule

// File: tb/tb_dram_arbiter.sv
// ----------------------------------------------------------------------------
// tb_dram_arbiter
//
// Self-checking bench for dram_arbiter with a behavioural DRAM (async read,
// write on the rising edge). A table of per-cycle vectors covers single-beat
// reads/writes, round-robin ties and address masking; hand-written sequences
// cover the burst cap, long single-master bursts and reset mid-write.
// ----------------------------------------------------------------------------
module tb_dram_arbiter;

    logic        clk;
    logic        rst;
    logic        m0_req, m0_we, m0_ack;
    logic [31:0] m0_addr, m0_wdata, m0_rdata;
    logic        m1_req, m1_we, m1_ack;
    logic [31:0] m1_addr, m1_wdata, m1_rdata;
    logic [15:0] dram_a;
    logic [31:0] dram_d, dram_spo;
    logic        dram_we;
    logic [1:0]  grant;

    logic [31:0] mem [0:65535];

    int checks = 0;
    int errors = 0;

    dram_arbiter #(
        .ADDR_W    (16),
        .DATA_W    (32),
        .MAX_BURST (8)
    ) dut (
        .cpu_clk_i  (clk),
        .cpu_rst_i  (rst),
        .m0_req_i   (m0_req),
        .m0_addr_i  (m0_addr),
        .m0_we_i    (m0_we),
        .m0_wdata_i (m0_wdata),
        .m0_ack_o   (m0_ack),
        .m0_rdata_o (m0_rdata),
        .m1_req_i   (m1_req),
        .m1_addr_i  (m1_addr),
        .m1_we_i    (m1_we),
        .m1_wdata_i (m1_wdata),
        .m1_ack_o   (m1_ack),
        .m1_rdata_o (m1_rdata),
        .dram_a_o   (dram_a),
        .dram_d_o   (dram_d),
        .dram_we_o  (dram_we),
        .dram_spo_i (dram_spo),
        .grant_o    (grant)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    assign dram_spo = mem[dram_a];
    always @(posedge clk) begin
        if (dram_we) mem[dram_a] <= dram_d;
    end

    typedef struct {
        logic        m0_req;
        logic [31:0] m0_addr;
        logic        m0_we;
        logic [31:0] m0_wdata;
        logic        m1_req;
        logic [31:0] m1_addr;
        logic        m1_we;
        logic [31:0] m1_wdata;
        logic [1:0]  grant;
        logic        ack0;
        logic        ack1;
        logic        we;
        logic [15:0] a;
        logic [31:0] d;
        logic [31:0] rd0;
        logic [31:0] rd1;
    } vec_t;

    vec_t vec [16];

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        m0_req = 0; m0_addr = 0; m0_we = 0; m0_wdata = 0;
        m1_req = 0; m1_addr = 0; m1_we = 0; m1_wdata = 0;
    endtask

    // Holds reset for a cycle with requests asserted, checks all outputs are
    // quiet, then releases reset at posedge+1 with idle inputs.
    task automatic reset_dut(input string tag);
        rst = 1'b1;
        m0_req = 1; m0_we = 1; m0_addr = 32'h10; m0_wdata = 32'h1;
        m1_req = 1; m1_we = 1; m1_addr = 32'h20; m1_wdata = 32'h2;
        next_cycle();
        check({tag, " rst grant"},  grant,    2'b00);
        check({tag, " rst acks"},   {m0_ack, m1_ack}, 2'b00);
        check({tag, " rst we"},     dram_we,  1'b0);
        check({tag, " rst a"},      dram_a,   16'h0);
        check({tag, " rst d"},      dram_d,   32'h0);
        check({tag, " rst rdata"},  {m0_rdata, m1_rdata}, 64'h0);
        idle_inputs();
        rst = 1'b0;
    endtask

    initial begin
        int m0_n;
        int m1_n;
        logic [1:0] eg;
        logic ea0, ea1;

        rst = 1'b1;
        idle_inputs();
        for (int i = 0; i < 65536; i++) mem[i] = 32'h0;
        mem[4]  = 32'hDEADBEEF;
        mem[12] = 32'h12345678;
        mem[16] = 32'h55AA55AA;

        //            m0 req/addr/we/wdata         m1 req/addr/we/wdata
        //            grant ack0 ack1 we a d rd0 rd1
        vec[0]  = '{1, 32'h10, 0, 0, 1, 32'h40, 0, 0,
                    2'b00, 0, 0, 0, 16'h0, 32'h0, 32'h0, 32'h0};
        vec[1]  = '{1, 32'h10, 0, 0, 1, 32'h40, 0, 0,
                    2'b01, 1, 0, 0, 16'h4, 32'h0, 32'hDEADBEEF, 32'h0};
        vec[2]  = '{0, 32'h0, 0, 0, 0, 32'h0, 0, 0,
                    2'b01, 0, 0, 0, 16'h0, 32'h0, 32'h0, 32'h0};
        vec[3]  = '{1, 32'h30, 0, 0, 1, 32'h40, 0, 0,
                    2'b00, 0, 0, 0, 16'h0, 32'h0, 32'h0, 32'h0};
        vec[4]  = '{1, 32'h30, 0, 0, 1, 32'h40, 0, 0,
                    2'b10, 0, 1, 0, 16'h10, 32'h0, 32'h0, 32'h55AA55AA};
        vec[5]  = '{1, 32'h30, 0, 0, 1, 32'h20, 1, 32'h0A5A5A5A,
                    2'b10, 0, 1, 1, 16'h8, 32'h0A5A5A5A, 32'h0, 32'h0};
        vec[6]  = '{1, 32'h20, 0, 0, 0, 32'h0, 0, 0,
                    2'b10, 0, 0, 0, 16'h0, 32'h0, 32'h0, 32'h0};
        vec[7]  = '{1, 32'h20, 0, 0, 0, 32'h0, 0, 0,
                    2'b01, 1, 0, 0, 16'h8, 32'h0, 32'h0A5A5A5A, 32'h0};
        vec[8]  = '{1, 32'hABC00032, 0, 0, 0, 32'h0, 0, 0,
                    2'b01, 1, 0, 0, 16'hC, 32'h0, 32'h12345678, 32'h0};
        vec[9]  = '{0, 32'h0, 0, 0, 0, 32'h0, 0, 0,
                    2'b01, 0, 0, 0, 16'h0, 32'h0, 32'h0, 32'h0};
        vec[10] = '{0, 32'h0, 0, 0, 0, 32'h0, 0, 0,
                    2'b00, 0, 0, 0, 16'h0, 32'h0, 32'h0, 32'h0};
        vec[11] = '{0, 32'h0, 0, 0, 1, 32'h44, 1, 32'h11112222,
                    2'b00, 0, 0, 0, 16'h0, 32'h0, 32'h0, 32'h0};
        vec[12] = '{0, 32'h0, 0, 0, 1, 32'h44, 1, 32'h11112222,
                    2'b10, 0, 1, 1, 16'h11, 32'h11112222, 32'h0, 32'h0};
        vec[13] = '{1, 32'h44, 0, 0, 0, 32'h0, 0, 0,
                    2'b10, 0, 0, 0, 16'h0, 32'h0, 32'h0, 32'h0};
        vec[14] = '{1, 32'h44, 0, 0, 0, 32'h0, 0, 0,
                    2'b01, 1, 0, 0, 16'h11, 32'h0, 32'h11112222, 32'h0};
        vec[15] = '{0, 32'h0, 0, 0, 0, 32'h0, 0, 0,
                    2'b01, 0, 0, 0, 16'h0, 32'h0, 32'h0, 32'h0};

        // ---- Table: reads, RAW through DRAM, round-robin ties, masking ----
        #2;
        reset_dut("tbl");
        for (int i = 0; i < 16; i++) begin
            m0_req = vec[i].m0_req; m0_addr = vec[i].m0_addr;
            m0_we  = vec[i].m0_we;  m0_wdata = vec[i].m0_wdata;
            m1_req = vec[i].m1_req; m1_addr = vec[i].m1_addr;
            m1_we  = vec[i].m1_we;  m1_wdata = vec[i].m1_wdata;
            #1;
            check($sformatf("v%0d grant", i), grant,    vec[i].grant);
            check($sformatf("v%0d ack0", i),  m0_ack,   vec[i].ack0);
            check($sformatf("v%0d ack1", i),  m1_ack,   vec[i].ack1);
            check($sformatf("v%0d we", i),    dram_we,  vec[i].we);
            check($sformatf("v%0d a", i),     dram_a,   vec[i].a);
            check($sformatf("v%0d d", i),     dram_d,   vec[i].d);
            check($sformatf("v%0d rd0", i),   m0_rdata, vec[i].rd0);
            check($sformatf("v%0d rd1", i),   m1_rdata, vec[i].rd1);
            next_cycle();
        end
        check("tbl mem[8]",  mem[8],  32'h0A5A5A5A);
        check("tbl mem[17]", mem[17], 32'h11112222);

        // ---- Burst cap: M1 wants 20 beats, M0 wants 3 from cycle 3 ----
        reset_dut("cap");
        m0_n = 0;
        m1_n = 0;
        for (int c = 0; c < 27; c++) begin
            m1_req  = (m1_n < 20);
            m1_addr = 32'h400 + 32'(m1_n) * 4;
            m0_req  = (c >= 3) && (m0_n < 3);
            m0_addr = 32'h500 + 32'(m0_n) * 4;
            #1;
            if (c == 0 || c == 26)      eg = 2'b00;
            else if (c >= 9 && c <= 12) eg = 2'b01;
            else                        eg = 2'b10;
            ea1 = (c >= 1 && c <= 8) || (c >= 13 && c <= 24);
            ea0 = (c >= 9 && c <= 11);
            check($sformatf("cap c%0d grant", c), grant,  eg);
            check($sformatf("cap c%0d ack0", c),  m0_ack, ea0);
            check($sformatf("cap c%0d ack1", c),  m1_ack, ea1);
            if (m0_ack) m0_n++;
            if (m1_ack) m1_n++;
            next_cycle();
        end
        check("cap m0 beats", m0_n, 3);
        check("cap m1 beats", m1_n, 20);

        // ---- Single master, 20 back-to-back write beats ----
        m0_n = 0;
        for (int c = 0; c < 22; c++) begin
            m0_req   = (m0_n < 20);
            m0_we    = 1'b1;
            m0_addr  = 32'h100 + 32'(m0_n) * 4;
            m0_wdata = 32'hC0DE0000 + 32'(m0_n);
            #1;
            ea0 = (c >= 1 && c <= 20);
            check($sformatf("solo c%0d ack0", c), m0_ack,  ea0);
            check($sformatf("solo c%0d we", c),   dram_we, ea0);
            check($sformatf("solo c%0d a", c),    dram_a,  ea0 ? 16'h40 + 16'(m0_n) : 16'h0);
            if (m0_ack) m0_n++;
            next_cycle();
        end
        check("solo beats",    m0_n,     20);
        check("solo mem[40]",  mem[16'h40], 32'hC0DE0000);
        check("solo mem[53]",  mem[16'h53], 32'hC0DE0013);
        idle_inputs();

        // ---- Reset in the middle of an M0 write burst ----
        m0_req = 1; m0_we = 1; m0_addr = 32'h200; m0_wdata = 32'hAAAA0001;
        #1;
        check("rstmid arb grant", grant, 2'b00);
        next_cycle();
        check("rstmid b1 ack", m0_ack,  1'b1);
        check("rstmid b1 we",  dram_we, 1'b1);
        next_cycle();
        m0_addr = 32'h204; m0_wdata = 32'hBBBB0002;
        #1;
        check("rstmid b2 ack", m0_ack,  1'b1);
        check("rstmid b2 we",  dram_we, 1'b1);
        #1;
        rst = 1'b1;
        #1;
        check("rstmid async ack",   m0_ack,  1'b0);
        check("rstmid async we",    dram_we, 1'b0);
        check("rstmid async grant", grant,   2'b00);
        next_cycle();
        check("rstmid committed b1", mem[16'h80], 32'hAAAA0001);
        check("rstmid dropped b2",   mem[16'h81], 32'h0);
        idle_inputs();
        rst = 1'b0;

        // After reset M0 wins a tie again.
        m0_req = 1; m1_req = 1;
        m0_addr = 32'h10; m1_addr = 32'h40;
        next_cycle();
        check("post-rst tie grant", grant,  2'b01);
        check("post-rst tie ack0",  m0_ack, 1'b1);
        check("post-rst tie rd0",   m0_rdata, 32'hDEADBEEF);
        idle_inputs();
        next_cycle();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
